// File: rtl/hmac_sha3_resp.sv
// HMAC-SHA3-256 responder: sequences four absorb/permute phases on an external Keccak-f[1600] engine.
// Optional key cache (post-IKEY / post-OKEY states) enabled by defining HMAC_KEY_CACHE_EN.
module hmac_sha3_resp #(
  parameter int         RATE      = 1088,
  parameter int         DIGEST    = 256,
  parameter logic [7:0] IPAD_BYTE = 8'h36,
  parameter logic [7:0] OPAD_BYTE = 8'h5C
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [RATE-1:0]    key,
  input  logic [RATE-1:0]    message,
  output logic [DIGEST-1:0]  mac_value,
  output logic               ready,
  output logic               o_perm_start,
  output logic [1599:0]      o_perm_state,
  input  logic [1599:0]      i_perm_state,
  input  logic               i_perm_done
);

  localparam int STATE_W = 1600;
  localparam int CAP     = STATE_W - RATE;
  localparam logic [RATE-1:0] IPAD_BLK = {(RATE/8){IPAD_BYTE}};
  localparam logic [RATE-1:0] OPAD_BLK = {(RATE/8){OPAD_BYTE}};

  typedef enum logic [2:0] {IDLE, IKEY, IMSG, OKEY, ODIG, FIN} state_e;

  function automatic logic [STATE_W-1:0] absorb(input logic [STATE_W-1:0] s,
                                                input logic [RATE-1:0]    blk);
    return s ^ {blk, {CAP{1'b0}}};
  endfunction

  // Outer block: inner digest followed by SHA3 domain bits and final pad bit.
  function automatic logic [RATE-1:0] dig_blk(input logic [DIGEST-1:0] d);
    logic [RATE-1:0] b;
    b = '0;
    b[RATE-1 -: DIGEST]     = d;
    b[RATE-DIGEST-1 -: 3]   = 3'b011;
    b[0]                    = 1'b1;
    return b;
  endfunction

  state_e               state_q, state_d;
  logic [STATE_W-1:0]   sponge_q, sponge_d;
  logic [STATE_W-1:0]   perm_state_q, perm_state_d;
  logic                 perm_start_q, perm_start_d;
  logic [RATE-1:0]      key_q, key_d;
  logic [RATE-1:0]      msg_q, msg_d;
  logic [DIGEST-1:0]    inner_q, inner_d;
  logic [DIGEST-1:0]    mac_q, mac_d;
  logic                 done_ok;

`ifdef HMAC_KEY_CACHE_EN
  logic [STATE_W-1:0]   cache_i_q, cache_i_d;
  logic [STATE_W-1:0]   cache_o_q, cache_o_d;
  logic [RATE-1:0]      cache_key_q, cache_key_d;
  logic                 cache_vld_q, cache_vld_d;
  logic                 hit_q, hit_d;
`endif

  // Done is only meaningful once the request cycle has passed.
  assign done_ok = i_perm_done && !perm_start_q;

  always_comb begin
    state_d      = state_q;
    sponge_d     = sponge_q;
    perm_state_d = perm_state_q;
    perm_start_d = 1'b0;
    key_d        = key_q;
    msg_d        = msg_q;
    inner_d      = inner_q;
    mac_d        = mac_q;
`ifdef HMAC_KEY_CACHE_EN
    cache_i_d    = cache_i_q;
    cache_o_d    = cache_o_q;
    cache_key_d  = cache_key_q;
    cache_vld_d  = cache_vld_q;
    hit_d        = hit_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          key_d        = key;
          msg_d        = message;
          sponge_d     = '0;
          perm_start_d = 1'b1;
          state_d      = IKEY;
          perm_state_d = absorb('0, key ^ IPAD_BLK);
`ifdef HMAC_KEY_CACHE_EN
          hit_d = cache_vld_q && (key == cache_key_q);
          if (cache_vld_q && (key == cache_key_q)) begin
            sponge_d     = cache_i_q;
            state_d      = IMSG;
            perm_state_d = absorb(cache_i_q, message);
          end
`endif
        end
      end
      IKEY: begin
        if (done_ok) begin
          sponge_d     = i_perm_state;
`ifdef HMAC_KEY_CACHE_EN
          cache_i_d    = i_perm_state;
`endif
          perm_state_d = absorb(sponge_d, msg_q);
          perm_start_d = 1'b1;
          state_d      = IMSG;
        end
      end
      IMSG: begin
        if (done_ok) begin
          inner_d      = i_perm_state[STATE_W-1 -: DIGEST];
          sponge_d     = '0;
          perm_state_d = absorb('0, key_q ^ OPAD_BLK);
          perm_start_d = 1'b1;
          state_d      = OKEY;
`ifdef HMAC_KEY_CACHE_EN
          if (hit_q) begin
            sponge_d     = cache_o_q;
            perm_state_d = absorb(cache_o_q, dig_blk(inner_d));
            state_d      = ODIG;
          end
`endif
        end
      end
      OKEY: begin
        if (done_ok) begin
          sponge_d     = i_perm_state;
`ifdef HMAC_KEY_CACHE_EN
          cache_o_d    = i_perm_state;
`endif
          perm_state_d = absorb(sponge_d, dig_blk(inner_q));
          perm_start_d = 1'b1;
          state_d      = ODIG;
        end
      end
      ODIG: begin
        if (done_ok) begin
          sponge_d = i_perm_state;
          mac_d    = i_perm_state[STATE_W-1 -: DIGEST];
          state_d  = FIN;
        end
      end
      FIN: begin
        state_d = IDLE;
`ifdef HMAC_KEY_CACHE_EN
        if (!hit_q) begin
          cache_vld_d = 1'b1;
          cache_key_d = key_q;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      sponge_q     <= '0;
      perm_state_q <= '0;
      perm_start_q <= 1'b0;
      key_q        <= '0;
      msg_q        <= '0;
      inner_q      <= '0;
      mac_q        <= '0;
    end else begin
      state_q      <= state_d;
      sponge_q     <= sponge_d;
      perm_state_q <= perm_state_d;
      perm_start_q <= perm_start_d;
      key_q        <= key_d;
      msg_q        <= msg_d;
      inner_q      <= inner_d;
      mac_q        <= mac_d;
    end
  end

`ifdef HMAC_KEY_CACHE_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      cache_i_q   <= '0;
      cache_o_q   <= '0;
      cache_key_q <= '0;
      cache_vld_q <= 1'b0;
      hit_q       <= 1'b0;
    end else begin
      cache_i_q   <= cache_i_d;
      cache_o_q   <= cache_o_d;
      cache_key_q <= cache_key_d;
      cache_vld_q <= cache_vld_d;
      hit_q       <= hit_d;
    end
  end
`endif

  assign mac_value    = mac_q;
  assign ready        = (state_q == FIN);
  assign o_perm_start = perm_start_q;
  assign o_perm_state = perm_state_q;

endmodule

// File: tb/tb_hmac_sha3_resp.sv
// Randomized self-checking bench for hmac_sha3_resp with a NOT-permutation stub (P=3).
module tb_hmac_sha3_resp;
  localparam int RATE = 1088, DIGEST = 256, SW = 1600, P = 3;
`ifdef HMAC_KEY_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic              clk = 1'b0, rst = 1'b1, start = 1'b0;
  logic [RATE-1:0]   key = '0, message = '0;
  logic [DIGEST-1:0] mac_value;
  logic              ready, o_perm_start, i_perm_done;
  logic [SW-1:0]     o_perm_state;
  logic [SW-1:0]     stub_state = '0, held = '0;
  logic              stub_done = 1'b0, spur_done = 1'b0;

  hmac_sha3_resp dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .message(message),
    .mac_value(mac_value), .ready(ready), .o_perm_start(o_perm_start),
    .o_perm_state(o_perm_state), .i_perm_state(stub_state), .i_perm_done(i_perm_done)
  );

  assign i_perm_done = stub_done | spur_done;
  always #5 clk = ~clk;

  int cyc = 0, n_pstart = 0, n_ready = 0;
  int n_chk = 0, n_fail = 0;
  bit cvld = 1'b0;
  logic [RATE-1:0]   ckey = '0;
  logic [DIGEST-1:0] last_mac = '0;

  always @(posedge clk) begin
    cyc++;
    if (o_perm_start) n_pstart++;
    if (ready) n_ready++;
  end

  // Permutation stub: done exactly P cycles after the start pulse, result = ~state.
  int cnt = 0;
  always @(negedge clk) begin
    stub_done = 1'b0;
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        stub_done  = 1'b1;
        stub_state = ~held;
      end
    end
    if (o_perm_start) begin
      cnt  = P;
      held = o_perm_state;
    end
  end

  task automatic chk(input string tag, input logic [DIGEST-1:0] got, input logic [DIGEST-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [RATE-1:0] rnd_blk();
    logic [RATE-1:0] r;
    for (int i = 0; i < RATE/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Reference HMAC over the sponge, with the stub's permutation.
  function automatic logic [DIGEST-1:0] ref_hmac(input logic [RATE-1:0] k, input logic [RATE-1:0] m);
    logic [SW-1:0]     s;
    logic [DIGEST-1:0] inner;
    logic [RATE-1:0]   ob;
    s = '0;
    s = ~(s ^ {k ^ {136{8'h36}}, 512'd0});
    s = ~(s ^ {m, 512'd0});
    inner = s[SW-1 -: DIGEST];
    s = '0;
    s = ~(s ^ {k ^ {136{8'h5C}}, 512'd0});
    ob = {inner, 3'b011, 828'd0, 1'b1};
    s = ~(s ^ {ob, 512'd0});
    return s[SW-1 -: DIGEST];
  endfunction

  // mode: 0 plain, 1 extra start at cycle 5, 2 spurious done during the ready cycle
  task automatic do_req(input logic [RATE-1:0] k, input logic [RATE-1:0] m, input int mode);
    bit hit, seen;
    int s, lat, p0, r0;
    logic [DIGEST-1:0] e;
    hit = CACHE && cvld && (ckey == k);
    e   = ref_hmac(k, m);
    @(negedge clk);
    key = k; message = m; start = 1'b1;
    s = cyc; p0 = n_pstart; r0 = n_ready;
    @(negedge clk);
    start = 1'b0; key = rnd_blk(); message = rnd_blk();
    seen = 1'b0; lat = 0;
    for (int i = 0; i < 60; i++) begin
      if (ready) begin
        seen = 1'b1;
        lat  = cyc - s;
        break;
      end
      start = (mode == 1) && (cyc - s == 5);
      @(negedge clk);
    end
    start = 1'b0;
    chk("ready_seen", DIGEST'(seen), DIGEST'(1));
    chk("latency", DIGEST'(lat), hit ? DIGEST'(9) : DIGEST'(17));
    chk("mac", mac_value, e);
    chk("perm_starts", DIGEST'(n_pstart - p0), hit ? DIGEST'(2) : DIGEST'(4));
    last_mac = e;
    if (!hit) begin
      cvld = CACHE;
      ckey = k;
    end
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      chk("single_ready", DIGEST'(n_ready - r0), DIGEST'(1));
    end
    if (mode == 2) begin
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      chk("fin_spur_ready", DIGEST'(ready), DIGEST'(0));
      chk("fin_spur_mac", mac_value, e);
    end
  endtask

  task automatic reset_mid_op();
    int p0, r0;
    @(negedge clk);
    key = rnd_blk(); message = rnd_blk(); start = 1'b1;
    p0 = n_pstart; r0 = n_ready;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (n_pstart - p0 >= 2) break;
      @(negedge clk);
    end
    chk("rst_two_starts", DIGEST'(n_pstart - p0), DIGEST'(2));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    cvld = 1'b0;
    last_mac = '0;
    repeat (8) @(negedge clk);
    chk("rst_no_ready", DIGEST'(n_ready - r0), DIGEST'(0));
    chk("rst_mac", mac_value, '0);
    chk("rst_pstart", DIGEST'(o_perm_start), DIGEST'(0));
    chk("rst_pstate_zero", DIGEST'(|o_perm_state), DIGEST'(0));
  endtask

  task automatic spur_idle();
    int p0, r0;
    @(negedge clk);
    p0 = n_pstart; r0 = n_ready;
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_spur_ready", DIGEST'(n_ready - r0), DIGEST'(0));
    chk("idle_spur_pstart", DIGEST'(n_pstart - p0), DIGEST'(0));
    chk("idle_spur_mac", mac_value, last_mac);
  endtask

  logic [RATE-1:0] pool [3];

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("reset_mac", mac_value, '0);
    chk("reset_ready", DIGEST'(ready), DIGEST'(0));
    chk("reset_pstart", DIGEST'(o_perm_start), DIGEST'(0));
    chk("reset_pstate_zero", DIGEST'(|o_perm_state), DIGEST'(0));

    do_req('0, '0, 0);
    chk("kat_first", mac_value, {32{8'h6A}});
    do_req('0, '0, 0);
    chk("kat_b2b", mac_value, {32{8'h6A}});
    do_req({136{8'h01}}, '0, 0);
    do_req('0, rnd_blk(), 1);
    reset_mid_op();
    do_req(rnd_blk(), rnd_blk(), 0);
    spur_idle();
    do_req(rnd_blk(), rnd_blk(), 2);

    pool[0] = rnd_blk(); pool[1] = rnd_blk(); pool[2] = '0;
    for (int i = 0; i < 8; i++) begin
      if ($urandom_range(0, 3) == 0) do_req(rnd_blk(), rnd_blk(), 0);
      else do_req(pool[$urandom_range(0, 2)], rnd_blk(), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hmac_sha3_resp.md
Name: hmac_sha3_resp

Overview:
- HMAC-SHA3-256 responder. Serves the key-derivation controller's HMAC request interface: accepts a one-cycle start with a 1088-bit pre-padded message block, and returns a 256-bit MAC with a one-cycle ready pulse.
- Owns the 1600-bit sponge state. Sequences four absorb/permute phases on an external Keccak-f[1600] permutation engine through a start/done handshake.
- Sits between the PBKDF2 controller (upstream) and the shared permutation core (downstream).

Parameters:
- RATE, 1088, sponge rate in bits (SHA3-256); key and message block width.
- DIGEST, 256, MAC/digest width in bits.
- IPAD_BYTE, 8'h36, inner pad byte, replicated RATE/8 times.
- OPAD_BYTE, 8'h5C, outer pad byte, replicated RATE/8 times.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request pulse; sampled only in IDLE.
- key  in  RATE  HMAC key (password), already RATE bits wide.
- message  in  RATE  message block, already SHA3-padded by requester.
- mac_value  out  DIGEST  HMAC result; held until the next completion.
- ready  out  1  one-cycle pulse, mac_value valid.
- o_perm_start  out  1  one-cycle permutation request.
- o_perm_state  out  1600  state to permute; stable from o_perm_start until i_perm_done.
- i_perm_state  in  1600  permuted state; valid only in the i_perm_done cycle.
- i_perm_done  in  1  one-cycle permutation completion.

Behaviour:
- Reset values: mac_value=0, ready=0, o_perm_start=0, o_perm_state=0, FSM=IDLE, sponge=0. Reset mid-operation aborts immediately; an i_perm_done arriving after reset is ignored.
- Absorb: block XORed into sponge bits [1599:512]; bits [511:0] are capacity. Digest = sponge bits [1599:1344]. No byte reordering is done here (requester handles it).
- FSM states: IDLE, IKEY, IMSG, OKEY, ODIG, FIN.
- IDLE: on start, capture key and message into registers, clear sponge, go to IKEY.
- Each absorb state:
  - Entry cycle: o_perm_state = sponge XOR block, o_perm_start=1 for that cycle only.
  - Then wait for i_perm_done; on done, sponge <= i_perm_state and advance.
- Absorb blocks per state:
  - IKEY: key ^ {IPAD}.
  - IMSG: message.
  - After IMSG: inner digest <= sponge[1599:1344], sponge cleared.
  - OKEY: key ^ {OPAD}.
  - ODIG: {inner_digest, 3'b011, 828'd0, 1'b1}.
- FIN: mac_value <= sponge[1599:1344], ready=1 for one cycle, return to IDLE. A start in the cycle after the ready pulse is accepted.
- Latency: with permutation latency P (done P cycles after perm_start), ready is asserted 4P+5 cycles after the start cycle.
- start while not in IDLE is ignored; captured key/message are unaffected.
- i_perm_done while not waiting is ignored.
- Input key/message may change freely after the start cycle.

Optional Feature:
- Macro: HMAC_KEY_CACHE_EN.
- Defined:
  - Adds two 1600-bit cached states (post-IKEY, post-OKEY), a stored key, and a valid flag.
  - On start with valid=1 and key == stored key: skip IKEY and OKEY. Sponge is loaded from the cached state before IMSG and before ODIG. Latency = 2P+3.
  - On a miss: full flow, caches and stored key refreshed, valid set at FIN.
  - Reset clears valid.
- Undefined: no cache storage; every request takes 4P+5.

Test Plan:
- Stub permutation = bitwise NOT, P=3. key=0, message=0, start pulse -> exactly four o_perm_start pulses; ready at cycle 17 after start; mac_value={32{8'h6A}}.
- Same stub, second request with start issued 1 cycle after ready -> accepted; identical mac_value; ready again 17 cycles after that start.
- start pulsed again at cycle 5 of a busy request -> ignored; still exactly four perm_start pulses; single ready.
- rst asserted one cycle after the second o_perm_start, stub done arrives later -> all outputs 0, FSM IDLE, no ready; a fresh request then completes normally.
- Spurious i_perm_done in IDLE, and while in FIN -> no state change, no ready.
- HMAC_KEY_CACHE_EN, stub NOT, P=3: two requests with key=0 -> first ready at 17 cycles, second at 9 cycles, same mac_value; third request with key={136{8'h01}} -> ready at 17 cycles (miss).
